// File: rtl/tmem_pkg.sv
// Shared types and default constants for the test-memory arbiter.
//   state_e   : clear-sweep controller states (IDLE / CLEAR / DONE)
//   owner_e   : owner of an outstanding read (read-return routing tag)
//   rr_side_e : which requester was served last by the round-robin
package tmem_pkg;

   localparam int DEF_ADDR_W = 8;
   localparam int DEF_DATA_W = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CLEAR = 2'd1,
      DONE  = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_DBG  = 2'd1,
      OWN_BIST = 2'd2
   } owner_e;

   typedef enum logic {
      RR_DBG  = 1'b0,
      RR_BIST = 1'b1
   } rr_side_e;

endpackage

// File: rtl/tmem_rr_arbiter.sv
// Two-way request arbiter between the debug path and the BIST engine.
// Ports:
//   clk, rst              : TCK clock, async active-high reset
//   arb_en                : arbitration allowed this cycle (no clear running)
//   bist_mode             : BIST owns the memory; debug is never granted
//   dbg_req, bist_req     : requests
//   dbg_gnt, bist_gnt     : same-cycle grants (at most one high)
// Handshake: a requester holds req (and its command) until it sees gnt high
// in the same cycle; each gnt cycle carries exactly one access.
module tmem_rr_arbiter
   import tmem_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic arb_en,
   input  logic bist_mode,
   input  logic dbg_req,
   input  logic bist_req,
   output logic dbg_gnt,
   output logic bist_gnt
);

   rr_side_e rr_last_q;
   rr_side_e rr_last_d;

   always_comb begin
      dbg_gnt  = 1'b0;
      bist_gnt = 1'b0;
      if (arb_en) begin
         if (bist_mode) begin
            bist_gnt = bist_req;
         end else if (dbg_req && bist_req) begin
            // tie: the side that was not served last wins
            if (rr_last_q == RR_BIST) begin
               dbg_gnt = 1'b1;
            end else begin
               bist_gnt = 1'b1;
            end
         end else begin
            dbg_gnt  = dbg_req;
            bist_gnt = bist_req;
         end
      end
   end

   // every grant, including BIST-mode grants, moves the round-robin pointer
   always_comb begin
      rr_last_d = rr_last_q;
      if (dbg_gnt) begin
         rr_last_d = RR_DBG;
      end else if (bist_gnt) begin
         rr_last_d = RR_BIST;
      end
   end

   // reset to BIST so that debug wins the first tie
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_last_q <= RR_BIST;
      end else begin
         rr_last_q <= rr_last_d;
      end
   end

endmodule

// File: rtl/tmem_arbiter.sv
// Owner of the single TMemory port. Shares it between the JTAG debug path
// (read/write) and the BIST engine (read only), routes 1-cycle-latency read
// data back to the requester that issued the read, and runs a hardware clear
// sweep writing CLEAR_VALUE to addresses 0..MEM_DEPTH-1.
// Ports:
//   clk, rst                       : TCK clock, async active-high reset
//   runbist                        : BIST mode (level)
//   dbg_req/we/addr/wdata, dbg_gnt : debug command + same-cycle grant
//   dbg_rvalid, dbg_rdata          : debug read return
//   bist_req/addr, bist_gnt        : BIST read command + same-cycle grant
//   bist_rvalid, bist_rdata        : BIST read return
//   clear_start/busy/done          : clear sweep control and status
//   mem_*                          : TMemory port (read data valid the cycle
//                                    after mem_read_en)
module tmem_arbiter
   import tmem_pkg::*;
#(
   parameter int                 ADDR_W      = DEF_ADDR_W,
   parameter int                 DATA_W      = DEF_DATA_W,
   parameter int                 MEM_DEPTH   = 256,
   parameter logic [DATA_W-1:0]  CLEAR_VALUE = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              runbist,
   input  logic              dbg_req,
   input  logic              dbg_we,
   input  logic [ADDR_W-1:0] dbg_addr,
   input  logic [DATA_W-1:0] dbg_wdata,
   output logic              dbg_gnt,
   output logic              dbg_rvalid,
   output logic [DATA_W-1:0] dbg_rdata,
   input  logic              bist_req,
   input  logic [ADDR_W-1:0] bist_addr,
   output logic              bist_gnt,
   output logic              bist_rvalid,
   output logic [DATA_W-1:0] bist_rdata,
   input  logic              clear_start,
   output logic              clear_busy,
   output logic              clear_done,
   output logic              mem_write_en,
   output logic              mem_read_en,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_write_data,
   input  logic [DATA_W-1:0] mem_read_data
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   owner_e            tag_q, tag_d;
   logic              arb_en;

   assign arb_en = (state_q == IDLE);

   tmem_rr_arbiter u_rr (
      .clk       (clk),
      .rst       (rst),
      .arb_en    (arb_en),
      .bist_mode (runbist),
      .dbg_req   (dbg_req),
      .bist_req  (bist_req),
      .dbg_gnt   (dbg_gnt),
      .bist_gnt  (bist_gnt)
   );

   // memory command: sweep write, granted debug access, or granted BIST read
   always_comb begin
      mem_write_en   = 1'b0;
      mem_read_en    = 1'b0;
      mem_addr       = '0;
      mem_write_data = '0;
      if (state_q == CLEAR) begin
         mem_write_en   = 1'b1;
         mem_addr       = cnt_q;
         mem_write_data = CLEAR_VALUE;
      end else if (dbg_gnt) begin
         mem_addr = dbg_addr;
         if (dbg_we) begin
            mem_write_en   = 1'b1;
            mem_write_data = dbg_wdata;
         end else begin
            mem_read_en = 1'b1;
         end
      end else if (bist_gnt) begin
         mem_read_en = 1'b1;
         mem_addr    = bist_addr;
      end
   end

   // next state, sweep counter and read-owner tag
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      tag_d   = OWN_NONE;
      if (dbg_gnt && !dbg_we) begin
         tag_d = OWN_DBG;
      end else if (bist_gnt) begin
         tag_d = OWN_BIST;
      end
      case (state_q)
         IDLE: begin
            // a clear request is refused while BIST owns the memory
            if (clear_start && !runbist) begin
               state_d = CLEAR;
               cnt_d   = '0;
            end
         end
         CLEAR: begin
            if (cnt_q == LAST_ADDR) begin
               state_d = DONE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         tag_q   <= OWN_NONE;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         tag_q   <= tag_d;
      end
   end

   assign clear_busy  = (state_q != IDLE);
   assign clear_done  = (state_q == DONE);
   assign dbg_rvalid  = (tag_q == OWN_DBG);
   assign bist_rvalid = (tag_q == OWN_BIST);
   assign dbg_rdata   = dbg_rvalid  ? mem_read_data : '0;
   assign bist_rdata  = bist_rvalid ? mem_read_data : '0;

endmodule

// File: tb/tb_tmem_arbiter.sv
module tb_tmem_arbiter;

   localparam int MEM_DEPTH = 256;
   localparam logic [7:0] CLEAR_VALUE = 8'h00;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic       runbist = 0, dbg_req = 0, dbg_we = 0, bist_req = 0, clear_start = 0;
   logic [7:0] dbg_addr = 0, dbg_wdata = 0, bist_addr = 0;
   logic       dbg_gnt, dbg_rvalid, bist_gnt, bist_rvalid;
   logic [7:0] dbg_rdata, bist_rdata;
   logic       clear_busy, clear_done, mem_write_en, mem_read_en;
   logic [7:0] mem_addr, mem_write_data;
   logic [7:0] mem_read_data = 8'h00;

   tmem_arbiter dut (
      .clk            (clk),
      .rst            (rst),
      .runbist        (runbist),
      .dbg_req        (dbg_req),
      .dbg_we         (dbg_we),
      .dbg_addr       (dbg_addr),
      .dbg_wdata      (dbg_wdata),
      .dbg_gnt        (dbg_gnt),
      .dbg_rvalid     (dbg_rvalid),
      .dbg_rdata      (dbg_rdata),
      .bist_req       (bist_req),
      .bist_addr      (bist_addr),
      .bist_gnt       (bist_gnt),
      .bist_rvalid    (bist_rvalid),
      .bist_rdata     (bist_rdata),
      .clear_start    (clear_start),
      .clear_busy     (clear_busy),
      .clear_done     (clear_done),
      .mem_write_en   (mem_write_en),
      .mem_read_en    (mem_read_en),
      .mem_addr       (mem_addr),
      .mem_write_data (mem_write_data),
      .mem_read_data  (mem_read_data)
   );

   // ---------------- TMemory behavioural model ----------------
   logic [7:0] tmem [MEM_DEPTH];
   always @(posedge clk) begin
      if (mem_write_en) tmem[mem_addr] <= mem_write_data;
      if (mem_read_en)  mem_read_data  <= tmem[mem_addr];
   end

   // ---------------- reference model state ----------------
   logic [7:0] ref_mem [MEM_DEPTH];   // what the memory should contain
   logic [9:0] exp_q[$];              // {owner(1=dbg,2=bist), data} per pending read
   int         clear_left = 0;        // busy cycles still to come (sweep + done)
   logic       last_bist  = 1'b1;     // last served requester was BIST

   // observations of the most recent step
   logic       obs_dgnt, obs_bgnt, obs_dv, obs_bv, obs_we;
   logic [7:0] obs_dd;
   int         obs_busy_cnt, obs_done_cnt;
   logic       prev_busy = 1'b0;
   logic       first_idle_bgnt = 1'b0;

   int n_cmp = 0;
   int n_err = 0;

   // ---------------- scoreboard check ----------------
   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // One cycle: inputs already applied at the negedge; predict, compare, advance.
   task automatic step();
      logic       e_dg, e_bg, e_we, e_re, e_dv, e_bv, e_busy, e_done;
      logic [7:0] e_addr, e_wd, e_dd, e_bd;
      logic [9:0] ent;
      int         widx;
      #1;
      {e_dg, e_bg, e_we, e_re, e_dv, e_bv, e_busy, e_done} = '0;
      e_addr = '0; e_wd = '0; e_dd = '0; e_bd = '0;
      if (rst) begin
         exp_q.delete();
         clear_left = 0;
         last_bist  = 1'b1;
      end else begin
         e_busy = (clear_left > 0);
         e_done = (clear_left == 1);
         if (exp_q.size() > 0) begin
            ent = exp_q.pop_front();
            if (ent[9:8] == 2'd1) begin e_dv = 1'b1; e_dd = ent[7:0]; end
            else                  begin e_bv = 1'b1; e_bd = ent[7:0]; end
         end
         if (clear_left > 1) begin
            widx   = MEM_DEPTH + 1 - clear_left;
            e_we   = 1'b1;
            e_addr = widx[7:0];
            e_wd   = CLEAR_VALUE;
         end else if (clear_left == 0) begin
            if (runbist)                  e_bg = bist_req;
            else if (dbg_req && bist_req) begin
               if (last_bist) e_dg = 1'b1; else e_bg = 1'b1;
            end else begin
               e_dg = dbg_req;
               e_bg = bist_req;
            end
            if (e_dg) begin
               e_addr = dbg_addr;
               if (dbg_we) begin e_we = 1'b1; e_wd = dbg_wdata; end
               else        e_re = 1'b1;
            end else if (e_bg) begin
               e_addr = bist_addr;
               e_re   = 1'b1;
            end
         end
      end
      check_eq("dbg_gnt",     dbg_gnt,        e_dg);
      check_eq("bist_gnt",    bist_gnt,       e_bg);
      check_eq("mem_we",      mem_write_en,   e_we);
      check_eq("mem_re",      mem_read_en,    e_re);
      check_eq("mem_addr",    mem_addr,       e_addr);
      check_eq("mem_wdata",   mem_write_data, e_wd);
      check_eq("dbg_rvalid",  dbg_rvalid,     e_dv);
      check_eq("dbg_rdata",   dbg_rdata,      e_dd);
      check_eq("bist_rvalid", bist_rvalid,    e_bv);
      check_eq("bist_rdata",  bist_rdata,     e_bd);
      check_eq("clear_busy",  clear_busy,     e_busy);
      check_eq("clear_done",  clear_done,     e_done);
      obs_dgnt = dbg_gnt; obs_bgnt = bist_gnt; obs_we = mem_write_en;
      obs_dv = dbg_rvalid; obs_bv = bist_rvalid; obs_dd = dbg_rdata;
      if (clear_busy) obs_busy_cnt++;
      if (clear_done) obs_done_cnt++;
      if (prev_busy && !clear_busy) first_idle_bgnt = bist_gnt;
      prev_busy = clear_busy;
      if (!rst) begin
         if (e_dg) last_bist = 1'b0;
         if (e_bg) last_bist = 1'b1;
         if (e_re) exp_q.push_back({(e_dg ? 2'd1 : 2'd2), ref_mem[e_addr]});
         if (e_we) ref_mem[e_addr] = e_wd;
         if (clear_left > 0)                 clear_left--;
         else if (clear_start && !runbist)   clear_left = MEM_DEPTH + 1;
      end
      @(negedge clk);
   endtask

   // ---------------- driver tasks ----------------
   task automatic set_idle();
      dbg_req = 0; dbg_we = 0; bist_req = 0; clear_start = 0;
   endtask

   task automatic do_reset();
      set_idle();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      step();
   endtask

   task automatic dbg_access(input logic we, input logic [7:0] addr, input logic [7:0] data,
                             output logic granted);
      granted = 1'b0;
      dbg_req = 1; dbg_we = we; dbg_addr = addr; dbg_wdata = data;
      for (int i = 0; i < 16 && !granted; i++) begin
         step();
         granted = obs_dgnt;
      end
      dbg_req = 0; dbg_we = 0;
   endtask

   task automatic pulse_clear();
      clear_start = 1;
      step();
      clear_start = 0;
   endtask

   // ---------------- main sequence ----------------
   initial begin
      logic g;
      int   cnt_a, cnt_b;
      for (int i = 0; i < MEM_DEPTH; i++) begin
         tmem[i]    = 8'($urandom);
         ref_mem[i] = tmem[i];
      end
      @(negedge clk);
      // reset state: everything low while rst is held
      step();
      check_eq("rst_busy", clear_busy, 0);
      rst = 1'b0;
      step();

      // 1: debug write then read back
      dbg_access(1'b1, 8'h10, 8'hA5, g);
      check_eq("t1_wr_gnt", g, 1);
      dbg_access(1'b0, 8'h10, 8'h00, g);
      check_eq("t1_rd_gnt", g, 1);
      step();
      check_eq("t1_rvalid", obs_dv, 1);
      check_eq("t1_rdata",  obs_dd, 8'hA5);
      check_eq("t1_brvalid", obs_bv, 0);

      // 2: both requesting, round-robin alternation starting with debug
      do_reset();
      dbg_req = 1; dbg_we = 0; dbg_addr = 8'h30;
      bist_req = 1; bist_addr = 8'h20;
      for (int i = 0; i < 8; i++) begin
         step();
         check_eq("t2_rr_dbg", obs_dgnt, ((i % 2) == 0));
      end
      set_idle();
      step();

      // 3: BIST mode, debug writes never granted, memory never written
      runbist = 1;
      dbg_req = 1; dbg_we = 1; dbg_addr = 8'h55; dbg_wdata = 8'h77;
      bist_req = 1; bist_addr = 8'h20;
      cnt_a = 0; cnt_b = 0;
      for (int i = 0; i < 8; i++) begin
         step();
         cnt_a += obs_dgnt + obs_we;
         cnt_b += obs_bgnt;
      end
      check_eq("t3_dbg_or_wr", cnt_a, 0);
      check_eq("t3_bist_gnts", cnt_b, 8);
      set_idle();
      runbist = 0;
      step();

      // 4: clear sweep wipes written data, no grants while busy
      dbg_access(1'b1, 8'h00, 8'hFF, g);
      dbg_access(1'b1, 8'hFF, 8'hFF, g);
      obs_busy_cnt = 0; obs_done_cnt = 0;
      pulse_clear();
      cnt_a = 0;
      for (int i = 0; i < MEM_DEPTH + 1; i++) begin
         dbg_req = 1'($urandom); dbg_we = 1'($urandom); dbg_addr = 8'($urandom);
         bist_req = 1'($urandom); bist_addr = 8'($urandom);
         step();
         cnt_a += obs_dgnt + obs_bgnt;
      end
      set_idle();
      step();
      check_eq("t4_sweep_gnts", cnt_a, 0);
      check_eq("t4_busy_cyc",   obs_busy_cnt, 257);
      check_eq("t4_done_cnt",   obs_done_cnt, 1);
      dbg_access(1'b0, 8'h00, 8'h00, g);
      step();
      check_eq("t4_rd00", obs_dd, 8'h00);
      dbg_access(1'b0, 8'hFF, 8'h00, g);
      step();
      check_eq("t4_rdFF", obs_dd, 8'h00);

      // 5: async reset mid-sweep, then a full restart from address 0
      obs_done_cnt = 0;
      pulse_clear();
      repeat (64) step();
      #1;
      check_eq("t5_addr_40", mem_addr, 8'h40);
      rst = 1'b1;
      step();
      step();
      check_eq("t5_no_done", obs_done_cnt, 0);
      rst = 1'b0;
      step();
      pulse_clear();
      for (int i = 0; i < MEM_DEPTH + 3; i++) step();
      check_eq("t5_done_cnt", obs_done_cnt, 1);

      // 6: clear refused in BIST mode; runbist mid-sweep waits for completion
      runbist = 1;
      obs_busy_cnt = 0;
      pulse_clear();
      repeat (3) step();
      check_eq("t6_ignored", obs_busy_cnt, 0);
      runbist = 0;
      obs_done_cnt = 0;
      first_idle_bgnt = 0;
      pulse_clear();
      repeat (100) step();
      runbist = 1; bist_req = 1; bist_addr = 8'h33; dbg_req = 1; dbg_we = 0;
      repeat (170) step();
      check_eq("t6_done_cnt", obs_done_cnt, 1);
      check_eq("t6_first_bgnt", first_idle_bgnt, 1);
      set_idle();
      runbist = 0;
      step();

      // random traffic against the model
      for (int i = 0; i < 700; i++) begin
         dbg_req     = ($urandom_range(0, 2) != 0);
         dbg_we      = 1'($urandom);
         dbg_addr    = 8'($urandom_range(0, 15));
         dbg_wdata   = 8'($urandom);
         bist_req    = ($urandom_range(0, 2) != 0);
         bist_addr   = 8'($urandom_range(0, 15));
         clear_start = ($urandom_range(0, 199) == 0);
         if ($urandom_range(0, 19) == 0) runbist = ~runbist;
         step();
      end
      set_idle();
      runbist = 0;
      repeat (3) step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule

// File: doc/tmem_arbiter.md
Name: tmem_arbiter

Overview:
- Owns the single port of the test memory (TMemory) and shares it between two requesters: the JTAG debug path (reads and writes) and the BIST engine (reads only).
- Provides a request/grant handshake to each requester and routes the 1-cycle-latency read data back to whichever requester issued the read.
- Runs a hardware clear sweep on command; this replaces the bulk mem_reset path.
- Sits between DebugSYS/BIST_FSM and TMemory, clocked by TCK.

Parameters:
- ADDR_W, 8, address width.
- DATA_W, 8, data width.
- MEM_DEPTH, 256, number of words swept by a clear; must be ≤ 2**ADDR_W.
- CLEAR_VALUE, 8'h00, word written during a clear sweep.

Ports:
- clk  in  1  clock (TCK domain).
- rst  in  1  asynchronous, active-high reset.
- runbist  in  1  BIST mode; level-sensitive.
- dbg_req  in  1  debug access request.
- dbg_we  in  1  1 = write, 0 = read.
- dbg_addr  in  ADDR_W  debug address.
- dbg_wdata  in  DATA_W  debug write data.
- dbg_gnt  out  1  debug access accepted this cycle.
- dbg_rvalid  out  1  debug read data valid.
- dbg_rdata  out  DATA_W  debug read data.
- bist_req  in  1  BIST read request.
- bist_addr  in  ADDR_W  BIST address.
- bist_gnt  out  1  BIST access accepted this cycle.
- bist_rvalid  out  1  BIST read data valid.
- bist_rdata  out  DATA_W  BIST read data.
- clear_start  in  1  single-cycle pulse; starts a clear sweep.
- clear_busy  out  1  sweep in progress.
- clear_done  out  1  single-cycle pulse when the sweep completes.
- mem_write_en  out  1  to TMemory.
- mem_read_en  out  1  to TMemory.
- mem_addr  out  ADDR_W  to TMemory.
- mem_write_data  out  DATA_W  to TMemory.
- mem_read_data  in  DATA_W  from TMemory; valid the cycle after mem_read_en.

Behaviour:
- Reset:
  - state = IDLE; clear counter = 0; rr_last = BIST, so debug wins the first tie.
  - Read-tag register = NONE.
  - All outputs are 0.
- States:
  - IDLE: no clear in progress; arbitration active.
  - CLEAR: sweep in progress; no grants issued.
  - DONE: one cycle; clear_done = 1; no grants; then return to IDLE.
- Transitions:
  - IDLE -> CLEAR on clear_start=1 with runbist=0. clear_start with runbist=1 is ignored.
  - CLEAR -> DONE after the write to address MEM_DEPTH-1.
  - DONE -> IDLE unconditionally.
- CLEAR sweep:
  - One write per cycle: mem_write_en=1, mem_addr = counter, mem_write_data = CLEAR_VALUE.
  - Counter runs 0..MEM_DEPTH-1. A full 256-word sweep takes 256 cycles in CLEAR, then 1 cycle in DONE.
  - clear_busy = 1 in CLEAR and DONE.
  - clear_start while busy is ignored.
  - runbist rising mid-sweep does not abort the sweep; BIST waits.
- Arbitration in IDLE (combinational grant, same cycle as the memory command):
  - runbist=1: BIST has fixed priority. dbg_gnt = 0 for all debug requests, reads and writes.
  - runbist=0, single requester: that requester is granted.
  - runbist=0, both requesting: round-robin; the requester not equal to rr_last wins.
  - rr_last updates on every grant.
- Memory command:
  - Granted debug write: mem_write_en=1, mem_addr=dbg_addr, mem_write_data=dbg_wdata.
  - Granted read (debug or BIST): mem_read_en=1, mem_addr = requester address.
  - No grant: mem_write_en = mem_read_en = 0; mem_addr and mem_write_data = 0.
- Requesters hold req/addr/data stable until they see gnt; one access per gnt cycle.
- Read return:
  - The tag register records the owner of a granted read.
  - Next cycle, the owner's rvalid = 1 for exactly one cycle, and its rdata = mem_read_data.
  - The other requester's rdata = 0.
  - Back-to-back reads are allowed every cycle; the tag is re-registered each cycle.
- Writes produce no rvalid.
- Async reset during CLEAR: immediate return to IDLE, counter = 0, no clear_done.
- Async reset during a read: the pending rvalid is dropped.
- A grant issued in the last cycle before runbist rises still returns its rvalid normally.

Decomposition:
- Package tmem_pkg:
  - State enum {IDLE, CLEAR, DONE}.
  - Owner enum {OWN_NONE, OWN_DBG, OWN_BIST}.
  - Default ADDR_W/DATA_W constants.
- One sub-module, tmem_rr_arbiter: 2-way round-robin with rr_last register and mode override.
- The clear counter and read-tag routing stay in the top module.

Test Plan:
1. Reset, then a debug write to 8'h10 with data 8'hA5, then a debug read of 8'h10 → dbg_gnt = 1 on each request; dbg_rvalid = 1 one cycle after the read grant with dbg_rdata = 8'hA5; bist_rvalid stays 0.
2. runbist=0, both requesting continuously (BIST at 8'h20, debug reads at 8'h30) → grants alternate DBG, BIST, DBG, BIST…; each rvalid routed to the correct owner with the correct data.
3. runbist=1, both requesting → bist_gnt = 1 every cycle; dbg_gnt = 0 throughout, including debug writes; the memory is never written.
4. Write 8'hFF to 8'h00 and 8'hFF, then pulse clear_start → clear_busy for 257 cycles; clear_done pulses once; debug reads of 8'h00 and 8'hFF then return 8'h00; requests during the sweep receive no grant.
5. Assert rst at sweep address 8'h40, then release and issue clear_start → no clear_done before the reset; after the restart the sweep begins at address 0 and completes.
6. clear_start with runbist=1 → ignored, clear_busy stays 0. Raise runbist mid-sweep → the sweep completes, then bist_gnt is issued on the first IDLE cycle.
